// File: rtl/cigar_run_encoder_if.sv
//------------------------------------------------------------------------------
// cigar_run_encoder_if : word-in / op-out valid-ready bundle of the CIGAR encoder
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cigar_run_encoder_if #(
  parameter int LEN_W = 12
) ();
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [LEN_W-1:0] op_len;
  logic             op_last;

  // master: word producer plus op consumer; slave: the encoder
  modport master (
    output in_valid, in_data, op_ready,
    input  in_ready, op_valid, op_code, op_len, op_last
  );

  modport slave (
    input  in_valid, in_data, op_ready,
    output in_ready, op_valid, op_code, op_len, op_last
  );
endinterface

`default_nettype wire

// File: rtl/cigar_run_encoder.sv
//------------------------------------------------------------------------------
// cigar_run_encoder : packed 2-bit traceback pointers -> run-length (code, len) ops
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cigar_run_encoder #(
  parameter int MAX_WORDS = 64,
  parameter int LEN_W     = 12
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               overflow_o,
  output logic [6:0]         word_count_o,
  cigar_run_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SCAN  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]       C_NONE      = 2'b00;
  localparam logic [LEN_W-1:0] C_LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] C_LEN_ONE   = LEN_W'(1);
  localparam logic [6:0]       C_MAX_WORDS = 7'(MAX_WORDS);

  state_t           state_q;
  state_t           next_q;
  logic [63:0]      shreg_q;
  logic [4:0]       ptr_idx_q;
  logic [1:0]       cur_code_q;
  logic [LEN_W-1:0] run_len_q;
  logic             flush_pend_q;
  logic [6:0]       word_count_q;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;
  logic             in_ready_q;
  logic             op_valid_q;
  logic [1:0]       op_code_q;
  logic [LEN_W-1:0] op_len_q;
  logic             op_last_q;

  logic [1:0] scan_ptr;
  logic       run_extend;
  logic       word_end;
  logic       last_word;

  assign scan_ptr   = shreg_q[63:62];
  assign run_extend = (scan_ptr == cur_code_q) && (run_len_q != C_LEN_MAX);
  assign word_end   = (ptr_idx_q == 5'd31);
  assign last_word  = (word_count_q == C_MAX_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      next_q       <= S_IDLE;
      shreg_q      <= '0;
      ptr_idx_q    <= '0;
      cur_code_q   <= C_NONE;
      run_len_q    <= '0;
      flush_pend_q <= 1'b0;
      word_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      op_valid_q   <= 1'b0;
      op_code_q    <= C_NONE;
      op_len_q     <= '0;
      op_last_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_FETCH;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            word_count_q <= '0;
            run_len_q    <= '0;
            cur_code_q   <= C_NONE;
            flush_pend_q <= 1'b0;
          end
        end

        S_FETCH: begin
          if (bus.in_valid) begin
            shreg_q      <= bus.in_data;
            ptr_idx_q    <= '0;
            word_count_q <= word_count_q + 7'd1;
            in_ready_q   <= 1'b0;
            state_q      <= S_SCAN;
          end
        end

        S_SCAN: begin
          shreg_q   <= {shreg_q[61:0], 2'b00};
          ptr_idx_q <= ptr_idx_q + 5'd1;
          if (scan_ptr == C_NONE) begin
            // Terminator: flush whatever is pending; an empty job yields (NONE, 0)
            op_code_q  <= (run_len_q == '0) ? C_NONE : cur_code_q;
            op_len_q   <= run_len_q;
            op_last_q  <= 1'b1;
            op_valid_q <= 1'b1;
            next_q     <= S_DONE;
            state_q    <= S_EMIT;
          end else if (run_extend) begin
            run_len_q <= run_len_q + C_LEN_ONE;
            if (word_end) begin
              if (last_word) begin
                op_code_q  <= cur_code_q;
                op_len_q   <= run_len_q + C_LEN_ONE;
                op_last_q  <= 1'b1;
                op_valid_q <= 1'b1;
                overflow_q <= 1'b1;
                next_q     <= S_DONE;
                state_q    <= S_EMIT;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= S_FETCH;
              end
            end
          end else begin
            cur_code_q <= scan_ptr;
            run_len_q  <= C_LEN_ONE;
            if (run_len_q != '0) begin
              op_code_q  <= cur_code_q;
              op_len_q   <= run_len_q;
              op_last_q  <= 1'b0;
              op_valid_q <= 1'b1;
              state_q    <= S_EMIT;
              // Differing pointer on the last slot of the last word: the new
              // one-pointer run still needs its own final op after this one.
              if (word_end && last_word) begin
                flush_pend_q <= 1'b1;
                next_q       <= S_DONE;
              end else begin
                next_q <= word_end ? S_FETCH : S_SCAN;
              end
            end else if (word_end) begin
              if (last_word) begin
                op_code_q  <= scan_ptr;
                op_len_q   <= C_LEN_ONE;
                op_last_q  <= 1'b1;
                op_valid_q <= 1'b1;
                overflow_q <= 1'b1;
                next_q     <= S_DONE;
                state_q    <= S_EMIT;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= S_FETCH;
              end
            end
          end
        end

        S_EMIT: begin
          if (bus.op_ready) begin
            if (flush_pend_q) begin
              op_code_q    <= cur_code_q;
              op_len_q     <= run_len_q;
              op_last_q    <= 1'b1;
              overflow_q   <= 1'b1;
              flush_pend_q <= 1'b0;
            end else begin
              op_valid_q <= 1'b0;
              state_q    <= next_q;
              if (next_q == S_FETCH) begin
                in_ready_q <= 1'b1;
              end
              if (next_q == S_DONE) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;
  assign word_count_o = word_count_q;
  assign bus.in_ready = in_ready_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_code  = op_code_q;
  assign bus.op_len   = op_len_q;
  assign bus.op_last  = op_last_q;

endmodule

`default_nettype wire
